// File: rtl/outreg_seq.sv
// Packer sequencer: accepts a code (valid/ready, at most one every 2 cycles), drains full bytes to IO RAM port B next cycle.
// Optional OUTSEQ_EOS_EN appends the end code on write_sp before the final flush; stalls code_ready while bytes are pending.
module outreg_seq #(
    parameter int          ADDR_W   = 10,
    parameter logic [12:0] EOS_CODE = 13'h1FFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              code_valid,
    input  logic [12:0]       code_data,
    input  logic              code_last,
    output logic              code_ready,
    output logic              write_data,
    output logic              write_sp,
    output logic              read_data,
    output logic [12:0]       prefix_data,
    input  logic              valid_dcnt,
    input  logic              tc_outreg,
    input  logic [7:0]        lzw_byte,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_cnt,
    output logic              ovf
);

    localparam int CODE_W = $bits(EOS_CODE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_DRAIN,
        S_EOS,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_r;
    // Extra top bit marks the address space as exhausted; it never wraps.
    logic [ADDR_W:0]   addr_r;

    always_comb begin
        state_nxt  = state;
        code_ready = 1'b0;
        write_data = 1'b0;
        write_sp   = 1'b0;
        read_data  = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ACCEPT;
            end
            S_ACCEPT: begin
                code_ready = 1'b1;
                if (code_valid) begin
                    write_data = 1'b1;
                    state_nxt  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (valid_dcnt) begin
                    read_data = 1'b1;
                end else if (last_r) begin
`ifdef OUTSEQ_EOS_EN
                    state_nxt = S_EOS;
`else
                    state_nxt = S_FLUSH;
`endif
                end else begin
                    state_nxt = S_ACCEPT;
                end
            end
`ifdef OUTSEQ_EOS_EN
            S_EOS: begin
                write_sp  = 1'b1;
                state_nxt = S_FLUSH;
            end
`endif
            S_FLUSH: begin
                // A pop with fewer than 8 bits held zero-pads and empties the packer.
                if (tc_outreg) state_nxt = S_DONE;
                else           read_data = 1'b1;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            last_r   <= 1'b0;
            addr_r   <= '0;
            byte_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                addr_r   <= {1'b0, start_addr};
                byte_cnt <= '0;
                ovf      <= 1'b0;
            end
            if (write_data) last_r <= code_last;
            // Dropped bytes are still popped so the packer stays in step.
            if (read_data) begin
                if (addr_r[ADDR_W]) begin
                    ovf <= 1'b1;
                end else begin
                    addr_r   <= addr_r + (ADDR_W + 1)'(1);
                    byte_cnt <= byte_cnt + (ADDR_W + 1)'(1);
                end
            end
        end
    end

    assign prefix_data = write_data ? CODE_W'(code_data) : '0;
    assign ram_we      = read_data & ~addr_r[ADDR_W];
    assign ram_addr    = addr_r[ADDR_W-1:0];
    assign ram_wdata   = ram_we ? lzw_byte : 8'h00;
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_outreg_seq.sv
// Bench for outreg_seq: environment packer model, table vectors, corner sequences and random streams vs a bit-queue reference.
module tb_outreg_seq;
    localparam int ADDR_W = 10;
    localparam int TOP    = 1 << ADDR_W;
`ifdef OUTSEQ_EOS_EN
    localparam bit EOS_ON = 1'b1;
`else
    localparam bit EOS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              code_valid = 1'b0;
    logic [12:0]       code_data = '0;
    logic              code_last = 1'b0;
    logic              code_ready, write_data, write_sp, read_data;
    logic [12:0]       prefix_data;
    logic              valid_dcnt, tc_outreg;
    logic [7:0]        lzw_byte;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              busy, done, ovf;
    logic [ADDR_W:0]   byte_cnt;

    outreg_seq #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .code_valid(code_valid), .code_data(code_data), .code_last(code_last),
        .code_ready(code_ready), .write_data(write_data), .write_sp(write_sp),
        .read_data(read_data), .prefix_data(prefix_data), .valid_dcnt(valid_dcnt),
        .tc_outreg(tc_outreg), .lzw_byte(lzw_byte), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .busy(busy), .done(done), .byte_cnt(byte_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Packer: bits held MSB-first in the low pk_cnt bits of pk_bits.
    logic [31:0] pk_bits;
    int          pk_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pk_bits <= '0;
            pk_cnt  <= 0;
        end else if (write_data) begin
            pk_bits <= (pk_bits << 13) | 32'(prefix_data);
            pk_cnt  <= pk_cnt + 13;
        end else if (write_sp) begin
            pk_bits <= (pk_bits << 13) | 32'h1FFF;
            pk_cnt  <= pk_cnt + 13;
        end else if (read_data) begin
            if (pk_cnt >= 8) begin
                pk_bits <= pk_bits & 32'((64'd1 << (pk_cnt - 8)) - 64'd1);
                pk_cnt  <= pk_cnt - 8;
            end else begin
                pk_bits <= '0;
                pk_cnt  <= 0;
            end
        end
    end
    assign valid_dcnt = (pk_cnt >= 8);
    assign tc_outreg  = (pk_cnt == 0);
    assign lzw_byte   = (pk_cnt >= 8) ? 8'(pk_bits >> (pk_cnt - 8)) : 8'(pk_bits << (8 - pk_cnt));

    int n_cmp = 0;
    int n_bad = 0;
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    logic [17:0] got_q[$];
    int          got_cyc[$];
    int          last_acc_cyc = 0;
    int          strobe_bad = 0, ready_bad = 0, pd_bad = 0, pk_max = 0;
    bit          prev_acc = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                got_q.push_back({ram_addr, ram_wdata});
                got_cyc.push_back(cyc);
            end
            if ((int'(write_data) + int'(write_sp) + int'(read_data)) > 1) strobe_bad++;
            if (code_ready && prev_acc) ready_bad++;
            if (!write_data && prefix_data != 13'h0) pd_bad++;
            if (code_valid && code_ready) last_acc_cyc = cyc;
            prev_acc = code_valid && code_ready;
            if (pk_cnt > pk_max) pk_max = pk_cnt;
        end
    end

    // Reference: concatenate code bits, append end code, zero-pad, split into bytes.
    logic [12:0] codes[$];
    logic [17:0] exp_q[$];
    int          exp_cnt;
    bit          exp_ovf;
    task automatic build_expected(input logic [ADDR_W-1:0] sa);
        bit          bq[$];
        int          a;
        logic [7:0]  by;
        exp_q.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
        foreach (codes[i]) for (int b = 12; b >= 0; b--) bq.push_back(codes[i][b]);
        if (EOS_ON) for (int b = 0; b < 13; b++) bq.push_back(1'b1);
        a = int'(sa);
        while (bq.size() > 0) begin
            by = 8'h00;
            for (int b = 7; b >= 0; b--) if (bq.size() > 0) by[b] = bq.pop_front();
            if (a < TOP) begin
                exp_q.push_back({10'(a), by});
                exp_cnt++;
                a++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    int  r_bc;
    bit  r_ov, r_done, r_tc;
    task automatic run_stream(input logic [ADDR_W-1:0] sa, input int gap_max, input int poke, input string nm);
        bit acc;
        int g;
        got_q.delete();
        got_cyc.delete();
        start = 1'b1;
        start_addr = sa;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < codes.size(); i++) begin
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            repeat (g) begin
                code_valid = 1'b0;
                code_last  = 1'($urandom);
                @(posedge clk); #1;
            end
            code_valid = 1'b1;
            code_data  = codes[i];
            code_last  = (i == codes.size() - 1);
            acc = 1'b0;
            for (int k = 0; k < 64 && !acc; k++) begin
                @(negedge clk);
                acc = code_ready;
                @(posedge clk); #1;
            end
            code_valid = 1'b0;
            code_last  = 1'b0;
            if (!acc) check({nm, " accept_timeout"}, 0, 1);
        end
        r_done = 1'b0;
        r_bc = 0;
        r_ov = 1'b0;
        r_tc = 1'b0;
        for (int k = 1; k < 400 && !r_done; k++) begin
            if (k == poke) begin
                start = 1'b1;
                start_addr = 10'h200;
            end
            @(negedge clk);
            if (done) begin
                r_done = 1'b1;
                r_bc = int'(byte_cnt);
                r_ov = ovf;
                r_tc = tc_outreg;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        check({nm, " done_one_cycle"}, done, 0);
        @(posedge clk); #1;
    endtask

    task automatic compare_stream(input string nm);
        check({nm, " done_seen"}, r_done, 1);
        check({nm, " nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s wr%0d addr_data", nm, i), got_q[i], exp_q[i]);
        check({nm, " byte_cnt"}, r_bc, exp_cnt);
        check({nm, " ovf"}, r_ov, exp_ovf);
        check({nm, " packer_empty"}, r_tc, 1);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " ctl"}, {code_ready, write_data, write_sp, read_data, prefix_data, busy, done, ovf}, 0);
        check({nm, " ram_cnt"}, {ram_we, ram_addr, ram_wdata, byte_cnt}, 0);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] sa;
        int                n;
        logic [12:0]       c0, c1, c2;
        int                cnt_eos, cnt_noeos;
        bit                ovf_eos, ovf_noeos;
    } vec_t;
    vec_t vt[6];

    logic [7:0] s1_bytes[$];
    task automatic check_s1(input string nm);
        check({nm, " s1_nbytes"}, got_q.size(), s1_bytes.size());
        for (int i = 0; i < got_q.size() && i < s1_bytes.size(); i++)
            check($sformatf("%s s1_b%0d", nm, i), got_q[i], {10'(16 + i), s1_bytes[i]});
    endtask

    task automatic load_codes(input int idx);
        codes.delete();
        codes.push_back(vt[idx].c0);
        if (vt[idx].n > 1) codes.push_back(vt[idx].c1);
        if (vt[idx].n > 2) codes.push_back(vt[idx].c2);
    endtask

    initial begin
        vt[0] = '{10'h010, 1, 13'h0041, 13'h0000, 13'h0000, 4, 2, 1'b0, 1'b0};
        vt[1] = '{10'h100, 3, 13'h1FFF, 13'h0000, 13'h1FFF, 7, 5, 1'b0, 1'b0};
        vt[2] = '{10'h3FE, 2, 13'h0AAA, 13'h1555, 13'h0000, 2, 2, 1'b1, 1'b1};
        vt[3] = '{10'h3FF, 1, 13'h0041, 13'h0000, 13'h0000, 1, 1, 1'b1, 1'b1};
        vt[4] = '{10'h3FC, 1, 13'h0041, 13'h0000, 13'h0000, 4, 2, 1'b0, 1'b0};
        vt[5] = '{10'h000, 3, 13'h1234, 13'h0FFF, 13'h0001, 7, 5, 1'b0, 1'b0};
        if (EOS_ON) begin
            s1_bytes.push_back(8'h02); s1_bytes.push_back(8'h0F);
            s1_bytes.push_back(8'hFF); s1_bytes.push_back(8'hC0);
        end else begin
            s1_bytes.push_back(8'h02); s1_bytes.push_back(8'h08);
        end

        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 6; r++) begin
            string nm;
            nm = $sformatf("vec%0d", r);
            load_codes(r);
            build_expected(vt[r].sa);
            run_stream(vt[r].sa, 0, 0, nm);
            compare_stream(nm);
            check({nm, " tbl_cnt"}, r_bc, EOS_ON ? vt[r].cnt_eos : vt[r].cnt_noeos);
            check({nm, " tbl_ovf"}, r_ov, EOS_ON ? vt[r].ovf_eos : vt[r].ovf_noeos);
            if (r == 0) begin
                check_s1(nm);
                if (got_cyc.size() > 0) check("vec0 first_byte_latency", got_cyc[0] - last_acc_cyc, 1);
            end
        end

        // Reset in DRAIN with 13 bits held, then replay the single-code stream.
        start = 1'b1;
        start_addr = 10'h010;
        @(posedge clk); #1;
        start = 1'b0;
        code_valid = 1'b1;
        code_data = 13'h0041;
        code_last = 1'b0;
        @(posedge clk); #1;
        code_valid = 1'b0;
        check("pre_rst bits_held", pk_cnt, 13);
        check("pre_rst read_data", read_data, 1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        load_codes(0);
        build_expected(10'h010);
        run_stream(10'h010, 0, 0, "after_rst");
        compare_stream("after_rst");
        check_s1("after_rst");

        // start pulsed during FLUSH must be ignored.
        run_stream(10'h010, 0, 4, "start_in_flush");
        compare_stream("start_in_flush");
        check_s1("start_in_flush");
        repeat (4) @(posedge clk);
        #1;
        check("start_in_flush idle", busy, 0);
        check("start_in_flush no_extra_wr", got_q.size(), exp_q.size());
        check("start_in_flush cnt_stable", byte_cnt, exp_cnt);

        for (int t = 0; t < 40; t++) begin
            logic [ADDR_W-1:0] sa;
            int n;
            string nm;
            nm = $sformatf("rnd%0d", t);
            sa = ($urandom_range(0, 3) == 0) ? 10'(TOP - $urandom_range(1, 8)) : 10'($urandom);
            n = $urandom_range(1, 8);
            codes.delete();
            for (int i = 0; i < n; i++) codes.push_back(13'($urandom));
            build_expected(sa);
            run_stream(sa, 3, $urandom_range(0, 10), nm);
            compare_stream(nm);
        end

        check("strobe_exclusive", strobe_bad, 0);
        check("ready_not_back_to_back", ready_bad, 0);
        check("prefix_zero_when_idle", pd_bad, 0);
        check("packer_max_le_20", (pk_max <= 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/outreg_seq.md
Name: outreg_seq

Overview:
- Sequencer for the 13-bit-to-byte output packer in the LZW compressor output path.
- Accepts 13-bit codes from the compressor core over a valid/ready handshake and drives the packer strobes: write_data, write_sp and read_data.
- Drains every complete byte into IO RAM port B at consecutive addresses.
- At end of stream, appends the end code (if compiled in), flushes the partial last byte and reports completion and byte count.

Parameters:
ADDR_W, 10, IO RAM port B address width
EOS_CODE, 13'h1FFF, end-of-stream code value; documentation only, the packer inserts it on write_sp

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active high
start  input  1  one-cycle pulse; begins a stream; ignored outside IDLE
start_addr  input  ADDR_W  first IO RAM byte address; latched on start
code_valid  input  1  code available
code_data  input  13  code value
code_last  input  1  qualifies code_valid; this code is the last of the stream
code_ready  output  1  code accepted when code_valid & code_ready
write_data  output  1  to packer: load prefix_data
write_sp  output  1  to packer: load end code
read_data  output  1  to packer: pop one byte
prefix_data  output  13  to packer: code value
valid_dcnt  input  1  from packer: 8 or more bits held
tc_outreg  input  1  from packer: 0 bits held
lzw_byte  input  8  from packer: current top byte (combinational)
ram_we  output  1  IO RAM port B write enable
ram_addr  output  ADDR_W  IO RAM port B address
ram_wdata  output  8  IO RAM port B write data
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at stream end
byte_cnt  output  ADDR_W+1  bytes written this stream; stable from done until the next start
ovf  output  1  sticky: at least one byte dropped at the top of the address space; cleared on start

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs are 0, including code_ready, strobes, ram_*, byte_cnt and ovf.
- The packer uses the same reset, inverted at top level, so a mid-stream reset returns both blocks to empty with no residue.
- Strobe rules: at most one of write_data, write_sp, read_data per cycle; all are combinational decodes of state and inputs.
- FSM states and transitions:
  - IDLE: on start, latch start_addr into the address register, clear byte_cnt and ovf, go to ACCEPT.
  - ACCEPT: code_ready=1. On code_valid, assert write_data with prefix_data=code_data in the same cycle, latch code_last into last_r, go to DRAIN. prefix_data=0 whenever write_data=0.
  - DRAIN: the packer count has updated by this cycle.
    - If valid_dcnt: assert read_data, ram_we=1, ram_wdata=lzw_byte, increment address and byte_cnt; stay in DRAIN.
    - Else if last_r: go to EOS.
    - Else: go to ACCEPT.
  - EOS: assert write_sp for one cycle, go to FLUSH.
  - FLUSH:
    - If tc_outreg: go to DONE.
    - Else: assert read_data and write the byte exactly as in DRAIN, then stay. A read with fewer than 8 bits held zero-pads the byte and clears the packer count.
  - DONE: done=1 for one cycle, go to IDLE.
- Latency: code accepted at cycle T; its first byte is written at T+1 if 8 or more bits are held. Back-to-back codes with no full byte pending: one accept every 2 cycles.
- Packer count never exceeds 20: a code is only accepted when the count is below 8.
- Address wrap: after a write at address 2^ADDR_W-1, further writes in the stream set ovf and hold ram_we=0. read_data is still issued so the packer stays consistent. byte_cnt counts only bytes actually written; the address does not wrap.
- start while busy: ignored.
- code_last with code_ready low: no effect.

Optional Feature:
OUTSEQ_EOS_EN
- Defined: EOS state present; the end code is appended before the flush.
- Undefined: DRAIN goes directly to FLUSH when last_r is set; write_sp is tied 0.

Test Plan:
- EOS_EN defined, start_addr=0x010, single code 0x0041 with last -> writes 0x02@0x010, 0x0F@0x011, 0xFF@0x012, 0xC0@0x013; then done pulse, byte_cnt=4, ovf=0.
- EOS_EN undefined, same stimulus -> writes 0x02@0x010, 0x08@0x011; byte_cnt=2.
- Codes 0x1FFF, 0x0000, 0x1FFF (last), code_valid held high -> code_ready is never high in consecutive cycles; total bytes = ceil(39 bits/8)=5 without EOS, ceil(52/8)=7 with EOS.
- start_addr=2^ADDR_W-2, stream producing 4 bytes -> 2 writes then ovf=1, byte_cnt=2, done still pulses, packer ends with tc_outreg=1.
- rst asserted in DRAIN with 13 bits held -> all outputs 0 the same cycle; a subsequent start and single code 0x0041 (EOS_EN defined) reproduces scenario 1 exactly.
- start pulsed during FLUSH -> ignored; byte_cnt and the address sequence are unchanged.
